hs_npu_layer_sequencer: RTL and testbench
=========================================

# hs_npu_layer_sequencer

Autonomous layer scheduler for the NPU. It walks a CPU-supplied list of layer descriptors in memory and fetches each descriptor over the shared memory read port. It presents the decoded layer configuration to `hs_npu_memory_ordering` through its exec handshake, waits for `finished`, then advances to the next layer. It owns the memory port only while fetching descriptors and hands it back to the ordering unit otherwise, so multi-layer inference runs without per-layer CPU intervention.

## Interface
Parameters:
- `BURST_SIZE`, default 2: 32-bit words per memory beat. Must divide 8.
- `MAX_LAYERS`, default 255: upper bound on the layer count; larger requests are clamped to this value.

Ports (`uword` = 32 bits):
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  begin sequencing; sampled only in IDLE.
- `abort_i`  in  1  stop sequencing; return to IDLE next cycle.
- `desc_base_i`  in  32  byte address of the first descriptor.
- `layer_count_i`  in  32  number of layers to run.
- `busy_o`  out  1  high in any state other than IDLE.
- `done_o`  out  1  one-cycle pulse when the list completes.
- `layers_done_o`  out  32  layers finished in the current run.
- `mem_owner_o`  out  1  1 when the sequencer drives the memory port (FETCH only).
- `mem_valid_i`  in  1  read data valid.
- `mem_read_ready_o`  out  1  read request/accept.
- `request_address`  out  32  read address.
- `memory_data_in`  in  32×BURST_SIZE  read data beat.
- `exec_valid_o`  out  1  layer configuration valid.
- `exec_ready_i`  in  1  ordering unit ready.
- `finished_i`  in  1  ordering unit layer-complete pulse.
- `num_input_rows_o`, `num_input_columns_o`, `num_weight_rows_o`, `num_weight_columns_o`, `shift_amount_o`, `base_address_o`, `result_address_o`  out  32 each  decoded configuration fields.
- `reuse_inputs_o`, `reuse_weights_o`, `save_outputs_o`, `use_bias_o`, `use_sum_o`, `activation_select_o`  out  1 each  decoded configuration flags.
- `perf_cycles_o`  out  32  run cycle count (see Configuration).

## Operation
- Descriptor: 8 words, 32 bytes, stored contiguously. Word layout:
  - w0: input rows.
  - w1: input columns.
  - w2: weight rows.
  - w3: weight columns.
  - w4: flags. Bit 0 reuse_inputs, 1 reuse_weights, 2 save_outputs, 3 use_bias, 4 use_sum, 5 activation_select, 6 LAST. Bits 31:7 are ignored.
  - w5: shift amount.
  - w6: base address.
  - w7: result address.
- State machine: IDLE → FETCH → ISSUE → WAIT → (FETCH | DONE) → IDLE.
- IDLE:
  - On `start_i`, latch `desc_ptr` = `desc_base_i` and `remaining` = min(`layer_count_i`, MAX_LAYERS).
  - Clear `layers_done_o` and the beat counter.
  - If `remaining` is 0, go to DONE; otherwise go to FETCH.
- FETCH:
  - `mem_owner_o` = 1 and `mem_read_ready_o` = 1.
  - `request_address` = `desc_ptr` + beat×4×BURST_SIZE.
  - Each cycle with `mem_valid_i`, store the BURST_SIZE words at word index beat×BURST_SIZE and increment the beat counter.
  - After beat 8/BURST_SIZE−1 is captured, go to ISSUE.
- ISSUE: `exec_valid_o` = 1 and configuration outputs are driven from the captured descriptor. On `exec_valid_o` && `exec_ready_i`, go to WAIT.
- WAIT:
  - Configuration outputs stay stable and `exec_valid_o` = 0.
  - On `finished_i`: increment `layers_done_o`, decrement `remaining`, and set `desc_ptr` += 32.
  - If LAST was set or `remaining` becomes 0, go to DONE; otherwise go to FETCH.
- DONE: assert `done_o` for one cycle, then go to IDLE.
- `abort_i` in any non-IDLE state: go to IDLE next cycle with no `done_o`. `exec_valid_o` and `mem_read_ready_o` drop that cycle. The ordering unit's in-flight layer is not cancelled.
- `finished_i` outside WAIT is ignored. `start_i` while busy is ignored.

## Timing
- Reset value of every output is 0, including all configuration fields and `request_address`.
- All outputs are registered or derived from state; nothing is combinational from inputs.
- `start_i` to first `mem_read_ready_o`: 1 cycle.
- Descriptor fetch takes at least 8/BURST_SIZE cycles (4 at default); stall cycles with `mem_valid_i` = 0 hold the address.
- Last captured beat to `exec_valid_o`: 1 cycle.
- `finished_i` to next FETCH, or to `done_o`: 1 cycle.
- Reset asserted mid-run returns everything to reset values immediately; no partial descriptor is retained.

## Configuration
- `HS_NPU_SEQ_PERF_EN` defined:
  - `perf_cycles_o` counts every cycle from `start_i` acceptance through DONE inclusive, saturating at 0xFFFFFFFF.
  - It holds its value in IDLE and clears on the next accepted start.
- Not defined: the counter logic is removed and `perf_cycles_o` is tied to 0.

## Test plan
- Single layer: base 0x1000, count 1, memory returns words 4,8,8,8,0x0D,3,0x2000,0x3000. Expect:
  - addresses 0x1000/0x1008/0x1010/0x1018;
  - ISSUE with rows 4, flags save_outputs = 1 and use_bias = 1, shift 3;
  - after `finished_i`, `done_o` pulse and `layers_done_o` = 1.
- Three layers with count 3: second fetch starts at 0x1020 and third at 0x1040; `done_o` follows the third `finished_i`; `layers_done_o` = 3.
- LAST flag in layer 2 with count 5: `done_o` after the second `finished_i`; `layers_done_o` = 2; no third fetch.
- Stalls: `mem_valid_i` toggling, with 3-cycle `exec_ready_i` delay. Address holds during stalls; `exec_valid_o` stays high until the handshake; config is unchanged.
- Count 0 gives `done_o` 2 cycles after start with no memory access. `abort_i` during WAIT gives IDLE next cycle, no `done_o`, and a subsequent `finished_i` is ignored.
- With `HS_NPU_SEQ_PERF_EN` defined: in the single-layer case with `finished_i` 20 cycles after the handshake, `perf_cycles_o` equals the measured start-to-DONE span. Without the macro it reads 0.

Source files
------------

// File: rtl/hs_npu_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : hs_npu_layer_sequencer
//  Purpose  : Walks a list of 8-word layer descriptors in memory. For each
//             layer it fetches the descriptor over the shared read port,
//             presents the decoded configuration to the ordering unit through
//             a valid/ready exec handshake, and waits for that unit's
//             layer-complete pulse before moving on to the next descriptor.
//  Ports    : clk/rst_n          - clock, asynchronous active-low reset
//             start_i/abort_i    - run control
//             desc_base_i        - byte address of the first descriptor
//             layer_count_i      - number of layers requested
//             busy_o/done_o      - run status
//             layers_done_o      - layers finished in the current run
//             mem_*/request_address/memory_data_in - descriptor read port
//             exec_valid_o/exec_ready_i/finished_i - ordering-unit handshake
//             *_o config fields  - decoded descriptor contents
//             perf_cycles_o      - run cycle count (optional)
//  Options  : HS_NPU_SEQ_PERF_EN - when defined, enables the saturating run
//             cycle counter; when undefined, perf_cycles_o is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module hs_npu_layer_sequencer #(
    parameter int BURST_SIZE = 2,
    parameter int MAX_LAYERS = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [31:0]               desc_base_i,
    input  logic [31:0]               layer_count_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [31:0]               layers_done_o,
    output logic                      mem_owner_o,
    input  logic                      mem_valid_i,
    output logic                      mem_read_ready_o,
    output logic [31:0]               request_address,
    input  logic [32*BURST_SIZE-1:0]  memory_data_in,
    output logic                      exec_valid_o,
    input  logic                      exec_ready_i,
    input  logic                      finished_i,
    output logic [31:0]               num_input_rows_o,
    output logic [31:0]               num_input_columns_o,
    output logic [31:0]               num_weight_rows_o,
    output logic [31:0]               num_weight_columns_o,
    output logic [31:0]               shift_amount_o,
    output logic [31:0]               base_address_o,
    output logic [31:0]               result_address_o,
    output logic                      reuse_inputs_o,
    output logic                      reuse_weights_o,
    output logic                      save_outputs_o,
    output logic                      use_bias_o,
    output logic                      use_sum_o,
    output logic                      activation_select_o,
    output logic [31:0]               perf_cycles_o
);

    localparam int          NUM_BEATS  = 8 / BURST_SIZE;
    localparam logic [3:0]  LAST_BEAT  = 4'(NUM_BEATS - 1);
    localparam logic [31:0] BEAT_BYTES = 32'(4 * BURST_SIZE);
    localparam logic [31:0] LAYER_CAP  = 32'(MAX_LAYERS);
    localparam logic [31:0] DESC_BYTES = 32'd32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_desc_ptr;
    logic [31:0] r_remaining;
    logic [31:0] r_layers_done;
    logic [3:0]  r_beat;
    logic [31:0] r_desc [0:7];

    logic [31:0] w_clamped;
    logic        w_start;
    logic        w_capture;
    logic        w_last_beat;
    logic        w_layer_end;
    logic        w_list_end;

    assign w_clamped   = (layer_count_i > LAYER_CAP) ? LAYER_CAP : layer_count_i;
    assign w_start     = (r_state == S_IDLE) && start_i;
    // Abort outranks every other event in the same cycle, so no beat is
    // captured and no layer is retired while leaving.
    assign w_capture   = (r_state == S_FETCH) && mem_valid_i && !abort_i;
    assign w_last_beat = w_capture && (r_beat == LAST_BEAT);
    assign w_layer_end = (r_state == S_WAIT) && finished_i && !abort_i;
    // r_remaining still holds the pre-decrement count here, so 1 means this
    // finishing layer is the final one.
    assign w_list_end  = r_desc[4][6] || (r_remaining == 32'd1);

    // ------------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort_i && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start_i)      w_next = (w_clamped == 32'd0) ? S_DONE : S_FETCH;
                S_FETCH: if (w_last_beat)  w_next = S_ISSUE;
                S_ISSUE: if (exec_ready_i) w_next = S_WAIT;
                S_WAIT:  if (finished_i)   w_next = w_list_end ? S_DONE : S_FETCH;
                S_DONE:                    w_next = S_IDLE;
                default:                   w_next = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Run bookkeeping and descriptor capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_desc_ptr    <= '0;
            r_remaining   <= '0;
            r_layers_done <= '0;
            r_beat        <= '0;
            for (int j = 0; j < 8; j++) begin
                r_desc[j] <= '0;
            end
        end else begin
            if (w_start) begin
                r_desc_ptr    <= desc_base_i;
                r_remaining   <= w_clamped;
                r_layers_done <= '0;
                r_beat        <= '0;
            end
            if (w_capture) begin
                // Word j of the descriptor arrives in beat j/BURST_SIZE at
                // lane j%BURST_SIZE.
                for (int j = 0; j < 8; j++) begin
                    if (4'(j / BURST_SIZE) == r_beat) begin
                        r_desc[j] <= memory_data_in[(j % BURST_SIZE)*32 +: 32];
                    end
                end
                r_beat <= w_last_beat ? 4'd0 : (r_beat + 4'd1);
            end
            if (w_layer_end) begin
                r_layers_done <= r_layers_done + 32'd1;
                r_remaining   <= r_remaining - 32'd1;
                r_desc_ptr    <= r_desc_ptr + DESC_BYTES;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional run cycle counter: covers the accepting IDLE cycle plus every
    // non-IDLE cycle of the run, and holds while idle.
    // ------------------------------------------------------------------------
`ifdef HS_NPU_SEQ_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf <= '0;
        end else if (w_start) begin
            r_perf <= 32'd1;
        end else if ((r_state != S_IDLE) && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles_o = r_perf;
`else
    assign perf_cycles_o = '0;
`endif

    // ------------------------------------------------------------------------
    // Outputs: all derived from state and registers
    // ------------------------------------------------------------------------
    assign busy_o           = (r_state != S_IDLE);
    assign done_o           = (r_state == S_DONE);
    assign layers_done_o    = r_layers_done;
    assign mem_owner_o      = (r_state == S_FETCH);
    assign mem_read_ready_o = (r_state == S_FETCH);
    assign exec_valid_o     = (r_state == S_ISSUE);
    assign request_address  = r_desc_ptr + ({28'd0, r_beat} * BEAT_BYTES);

    assign num_input_rows_o     = r_desc[0];
    assign num_input_columns_o  = r_desc[1];
    assign num_weight_rows_o    = r_desc[2];
    assign num_weight_columns_o = r_desc[3];
    assign reuse_inputs_o       = r_desc[4][0];
    assign reuse_weights_o      = r_desc[4][1];
    assign save_outputs_o       = r_desc[4][2];
    assign use_bias_o           = r_desc[4][3];
    assign use_sum_o            = r_desc[4][4];
    assign activation_select_o  = r_desc[4][5];
    assign shift_amount_o       = r_desc[5];
    assign base_address_o       = r_desc[6];
    assign result_address_o     = r_desc[7];

endmodule
`default_nettype wire

// File: tb/tb_hs_npu_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hs_npu_layer_sequencer
//  Purpose  : Scoreboard bench for hs_npu_layer_sequencer. Stimulus pushes
//             expected fetch addresses, exec configurations and completion
//             counts into queues; a monitor pops and compares them whenever
//             the DUT presents a memory beat, an exec handshake or done.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hs_npu_layer_sequencer;

    localparam int B    = 2;
    localparam int MAXL = 6;
    localparam int NB   = 8 / B;

    typedef logic [255:0] cfg_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_i = 1'b0;
    logic            abort_i = 1'b0;
    logic [31:0]     desc_base_i = '0;
    logic [31:0]     layer_count_i = '0;
    logic            busy_o, done_o, mem_owner_o, mem_read_ready_o, exec_valid_o;
    logic [31:0]     layers_done_o, request_address, perf_cycles_o;
    logic            mem_valid_i = 1'b0;
    logic [32*B-1:0] memory_data_in = '0;
    logic            exec_ready_i = 1'b0;
    logic            finished_i = 1'b0;
    logic [31:0]     num_input_rows_o, num_input_columns_o, num_weight_rows_o;
    logic [31:0]     num_weight_columns_o, shift_amount_o, base_address_o, result_address_o;
    logic            reuse_inputs_o, reuse_weights_o, save_outputs_o;
    logic            use_bias_o, use_sum_o, activation_select_o;

    always #5 clk = ~clk;

    hs_npu_layer_sequencer #(.BURST_SIZE(B), .MAX_LAYERS(MAXL)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .desc_base_i(desc_base_i), .layer_count_i(layer_count_i),
        .busy_o(busy_o), .done_o(done_o), .layers_done_o(layers_done_o),
        .mem_owner_o(mem_owner_o), .mem_valid_i(mem_valid_i),
        .mem_read_ready_o(mem_read_ready_o), .request_address(request_address),
        .memory_data_in(memory_data_in), .exec_valid_o(exec_valid_o),
        .exec_ready_i(exec_ready_i), .finished_i(finished_i),
        .num_input_rows_o(num_input_rows_o), .num_input_columns_o(num_input_columns_o),
        .num_weight_rows_o(num_weight_rows_o), .num_weight_columns_o(num_weight_columns_o),
        .shift_amount_o(shift_amount_o), .base_address_o(base_address_o),
        .result_address_o(result_address_o), .reuse_inputs_o(reuse_inputs_o),
        .reuse_weights_o(reuse_weights_o), .save_outputs_o(save_outputs_o),
        .use_bias_o(use_bias_o), .use_sum_o(use_sum_o),
        .activation_select_o(activation_select_o), .perf_cycles_o(perf_cycles_o)
    );

    // Backing memory (16 KiB, addresses wrap)
    logic [31:0] mem [0:4095];

    function automatic logic [31:0] rd(input logic [31:0] addr);
        return mem[addr[13:2]];
    endfunction

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        mem[addr[13:2]] = data;
    endtask

    // Scoreboard queues and counters
    logic [31:0] exp_addr_q [$];
    cfg_t        exp_cfg_q  [$];
    logic [31:0] exp_done_q [$];
    int          checks = 0;
    int          passes = 0;
    int          last_span = 0;

    // Responder knobs
    int valid_pct = 100;
    int rdy_delay = 0;
    int fin_delay = 2;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic fail(input string nm);
        checks++;
        $display("FAIL %s: event occurred with nothing expected", nm);
    endtask

    // Reference model: which addresses get fetched, which configs get issued,
    // and how many layers are reported when the list completes.
    task automatic model(input logic [31:0] base, input logic [31:0] cnt, input bit with_done);
        longint n;
        int     layers;
        n = (cnt > 32'(MAXL)) ? MAXL : longint'(cnt);
        layers = 0;
        for (int l = 0; l < n; l++) begin
            logic [31:0] a;
            cfg_t        c;
            a = base + 32'(32 * l);
            for (int b = 0; b < NB; b++) exp_addr_q.push_back(a + 32'(b * 4 * B));
            for (int w = 0; w < 8; w++) c[w*32 +: 32] = rd(a + 32'(4 * w));
            c[4*32 +: 32] = c[4*32 +: 32] & 32'h3F;
            exp_cfg_q.push_back(c);
            layers++;
            if (rd(a + 32'd16) & 32'h40) break;
        end
        if (with_done) exp_done_q.push_back(32'(layers));
    endtask

    // Writes n random descriptors; layer last_idx gets the LAST flag.
    task automatic put_list(input logic [31:0] base, input int n, input int last_idx);
        for (int l = 0; l < n; l++) begin
            logic [31:0] a;
            a = base + 32'(32 * l);
            for (int w = 0; w < 8; w++) wr(a + 32'(4 * w), $urandom);
            wr(a + 32'd16, ($urandom & 32'hFFFF_FFBF) | ((l == last_idx) ? 32'h40 : 32'h0));
        end
    endtask

    // Memory responder
    initial begin
        forever begin
            @(posedge clk); #1;
            mem_valid_i = mem_read_ready_o && ($urandom_range(0, 99) < valid_pct);
            for (int i = 0; i < B; i++) memory_data_in[i*32 +: 32] = rd(request_address + 32'(4 * i));
        end
    end

    // Ordering-unit responder
    initial begin
        bit fired;
        int rcnt, fcnt;
        fired = 0; rcnt = 0; fcnt = -1;
        forever begin
            @(posedge clk); #1;
            finished_i = 1'b0;
            if (fired) begin
                fired = 0;
                fcnt = fin_delay;
            end else if (fcnt == 0) begin
                finished_i = 1'b1;
                fcnt = -1;
            end else if (fcnt > 0) begin
                fcnt--;
            end
            if (exec_valid_o) begin
                if (rcnt >= rdy_delay) begin
                    exec_ready_i = 1'b1; fired = 1; rcnt = 0;
                end else begin
                    exec_ready_i = 1'b0; rcnt++;
                end
            end else begin
                exec_ready_i = 1'b0; rcnt = 0;
            end
        end
    end

    // Monitor
    initial begin
        bit span_on;
        int span;
        span_on = 0; span = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                span_on = 0;
                continue;
            end
            if (start_i && !busy_o) begin
                span_on = 1; span = 0;
            end
            if (span_on) span++;
            if (mem_read_ready_o && mem_valid_i) begin
                chk("mem_owner", 256'(mem_owner_o), 256'd1);
                if (exp_addr_q.size() == 0) fail("unexpected_fetch");
                else chk("fetch_addr", 256'(request_address), 256'(exp_addr_q.pop_front()));
            end
            if (exec_valid_o && exec_ready_i) begin
                cfg_t act;
                act = {result_address_o, base_address_o, shift_amount_o,
                       {26'd0, activation_select_o, use_sum_o, use_bias_o,
                        save_outputs_o, reuse_weights_o, reuse_inputs_o},
                       num_weight_columns_o, num_weight_rows_o,
                       num_input_columns_o, num_input_rows_o};
                if (exp_cfg_q.size() == 0) fail("unexpected_issue");
                else chk("exec_config", act, exp_cfg_q.pop_front());
            end
            if (done_o) begin
                if (exp_done_q.size() == 0) fail("unexpected_done");
                else chk("layers_done", 256'(layers_done_o), 256'(exp_done_q.pop_front()));
                span_on = 0;
                last_span = span;
            end
        end
    end

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (busy_o && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy_o) begin
            checks++;
            $display("FAIL %s_timeout: busy_o still %0d after %0d cycles", nm, busy_o, k);
        end
    endtask

    task automatic run(input logic [31:0] base, input logic [31:0] cnt, input string nm);
        int exp_perf;
        model(base, cnt, 1'b1);
        @(posedge clk); #1;
        desc_base_i = base; layer_count_i = cnt; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_idle(nm);
`ifdef HS_NPU_SEQ_PERF_EN
        exp_perf = last_span;
`else
        exp_perf = 0;
`endif
        chk("perf_cycles", 256'(perf_cycles_o), 256'(exp_perf));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_status", 256'({busy_o, done_o, mem_owner_o, mem_read_ready_o, exec_valid_o}), 256'd0);
        chk("reset_words", 256'({layers_done_o, request_address, perf_cycles_o, num_input_rows_o,
                                 shift_amount_o, base_address_o, result_address_o}), 256'd0);
        chk("reset_flags", 256'({reuse_inputs_o, reuse_weights_o, save_outputs_o, use_bias_o,
                                 use_sum_o, activation_select_o}), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single layer with the reference descriptor
        wr(32'h1000, 32'd4);      wr(32'h1004, 32'd8);      wr(32'h1008, 32'd8);
        wr(32'h100C, 32'd8);      wr(32'h1010, 32'h0D);     wr(32'h1014, 32'd3);
        wr(32'h1018, 32'h2000);   wr(32'h101C, 32'h3000);
        fin_delay = 20;
        run(32'h1000, 32'd1, "single");

        // Three layers, no LAST
        fin_delay = 2;
        put_list(32'h1000, 3, -1);
        run(32'h1000, 32'd3, "three");

        // LAST in layer 2 of 5
        put_list(32'h1200, 5, 1);
        run(32'h1200, 32'd5, "last_flag");

        // Stalls and slow exec_ready
        valid_pct = 40; rdy_delay = 3;
        put_list(32'h1400, 2, -1);
        run(32'h1400, 32'd2, "stall");
        valid_pct = 100; rdy_delay = 0;

        // Zero layers: accept cycle plus DONE
        run(32'h1600, 32'd0, "count0");
        chk("count0_span", 256'(last_span), 256'd2);

        // Count above MAX_LAYERS is clamped
        put_list(32'h1800, 8, -1);
        run(32'h1800, 32'd1000, "clamp");

        // Abort while waiting for finished
        fin_delay = 8;
        put_list(32'h2000, 3, -1);
        model(32'h2000, 32'd1, 1'b0);
        @(posedge clk); #1;
        desc_base_i = 32'h2000; layer_count_i = 32'd3; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        begin
            int k;
            k = 0;
            while (!(busy_o && !exec_valid_o && !mem_read_ready_o) && k < 200) begin
                @(posedge clk); #1;
                k++;
            end
            if (k >= 200) begin
                checks++;
                $display("FAIL abort_wait_timeout: WAIT not reached after %0d cycles", k);
            end
        end
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        chk("abort_idle", 256'({busy_o, exec_valid_o, mem_read_ready_o}), 256'd0);
        repeat (15) @(posedge clk);
        #1;
        chk("abort_layers", 256'(layers_done_o), 256'd0);
        chk("abort_stays_idle", 256'(busy_o), 256'd0);
        fin_delay = 2;

        // Reset in the middle of a run
        put_list(32'h2400, 4, -1);
        model(32'h2400, 32'd4, 1'b1);
        @(posedge clk); #1;
        desc_base_i = 32'h2400; layer_count_i = 32'd4; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", 256'({busy_o, exec_valid_o, mem_read_ready_o, layers_done_o,
                                    request_address, num_input_rows_o, result_address_o}), 256'd0);
        exp_addr_q.delete(); exp_cfg_q.delete(); exp_done_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised runs
        for (int r = 0; r < 10; r++) begin
            logic [31:0] base;
            int          n, last_idx;
            base      = 32'h3000 + 32'($urandom_range(0, 63) * 32);
            n         = $urandom_range(0, 9);
            last_idx  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 8) : -1;
            valid_pct = $urandom_range(30, 100);
            rdy_delay = $urandom_range(0, 3);
            fin_delay = $urandom_range(0, 6);
            put_list(base, (n > MAXL) ? MAXL : n, last_idx);
            run(base, 32'(n), "random");
        end

        repeat (3) @(posedge clk);
        #1;
        chk("addr_q_drained", 256'(exp_addr_q.size()), 256'd0);
        chk("cfg_q_drained", 256'(exp_cfg_q.size()), 256'd0);
        chk("done_q_drained", 256'(exp_done_q.size()), 256'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
